// File: rtl/bsg_cache_nb_to_test_dram_wr_split_pkg.sv
// Shared types for the non-blocking cache to test-DRAM request splitter.
// Holds the default configuration, the per-cache DMA packet struct, the
// splitter state enum and the tx side-path entry struct.
package bsg_cache_nb_test_dram_pkg;

    // Tag width helper: at least one bit even for a single requester.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned NUM_CACHE       = 2;
    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned BLOCK_WORDS     = 16;
    localparam int unsigned DRAM_DATA_WIDTH = 256;
    localparam int unsigned NUM_REQ         = BLOCK_WORDS * DATA_WIDTH / DRAM_DATA_WIDTH;
    localparam int unsigned SUB_MASK_WIDTH  = BLOCK_WORDS / NUM_REQ;
    localparam int unsigned LG_NUM_CACHE    = safe_clog2(NUM_CACHE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic                   write_not_read;
        logic [BLOCK_WORDS-1:0] mask;
    } dma_pkt_s;

    typedef struct packed {
        logic [LG_NUM_CACHE-1:0]   tag;
        logic [SUB_MASK_WIDTH-1:0] mask;
    } tx_entry_s;

endpackage

// File: rtl/bsg_cache_nb_to_test_dram_wr_split_if.sv
// Bus bundle between the caches' DMA packet ports, the test DRAM command
// port and the tx/rx tag side paths.
//   master : the splitter (drives yumi, dram_req_*, tx_*, rx_tag_*)
//   slave  : the environment (drives dma_pkt_*, and all ready inputs)
interface bsg_cache_nb_to_test_dram_wr_split_if
    import bsg_cache_nb_test_dram_pkg::*;
#(
    parameter int unsigned num_cache_p           = NUM_CACHE,
    parameter int unsigned addr_width_p          = ADDR_WIDTH,
    parameter int unsigned block_size_in_words_p = BLOCK_WORDS,
    parameter int unsigned sub_mask_width_lp     = SUB_MASK_WIDTH,
    parameter int unsigned lg_num_cache_lp       = LG_NUM_CACHE
);
    logic [num_cache_p-1:0]                       dma_pkt_v_i;
    logic [num_cache_p*addr_width_p-1:0]          dma_pkt_addr_i;
    logic [num_cache_p-1:0]                       dma_pkt_write_not_read_i;
    logic [num_cache_p*block_size_in_words_p-1:0] dma_pkt_mask_i;
    logic [num_cache_p-1:0]                       dma_pkt_yumi_o;

    logic                         dram_req_v_o;
    logic                         dram_req_write_not_read_o;
    logic [addr_width_p-1:0]      dram_req_addr_o;
    logic                         dram_req_ready_i;

    logic                         tx_v_o;
    logic [lg_num_cache_lp-1:0]   tx_tag_o;
    logic [sub_mask_width_lp-1:0] tx_mask_o;
    logic                         tx_ready_i;

    logic                         rx_tag_v_o;
    logic [lg_num_cache_lp-1:0]   rx_tag_o;
    logic                         rx_tag_ready_i;

    modport master (
        input  dma_pkt_v_i, dma_pkt_addr_i, dma_pkt_write_not_read_i, dma_pkt_mask_i,
        output dma_pkt_yumi_o,
        output dram_req_v_o, dram_req_write_not_read_o, dram_req_addr_o,
        input  dram_req_ready_i,
        output tx_v_o, tx_tag_o, tx_mask_o,
        input  tx_ready_i,
        output rx_tag_v_o, rx_tag_o,
        input  rx_tag_ready_i
    );

    modport slave (
        output dma_pkt_v_i, dma_pkt_addr_i, dma_pkt_write_not_read_i, dma_pkt_mask_i,
        input  dma_pkt_yumi_o,
        input  dram_req_v_o, dram_req_write_not_read_o, dram_req_addr_o,
        output dram_req_ready_i,
        input  tx_v_o, tx_tag_o, tx_mask_o,
        output tx_ready_i,
        input  rx_tag_v_o, rx_tag_o,
        output rx_tag_ready_i
    );

endinterface

// File: rtl/bsg_cache_nb_to_test_dram_wr_split_rr.sv
// Round-robin arbiter. Combinational grant from reqs_i starting at the
// priority pointer; the pointer moves past the winner only when yumi_i
// confirms the grant was taken.
// Ports: clk_i, reset_i (async, active-high), reqs_i, yumi_i,
//        grants_o (one-hot), tag_o (winner index), v_o (any request).
module bsg_arb_round_robin
    import bsg_cache_nb_test_dram_pkg::*;
#(
    parameter  int unsigned width_p     = 2,
    localparam int unsigned lg_width_lp = safe_clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     reqs_i,
    input  logic                   yumi_i,
    output logic [width_p-1:0]     grants_o,
    output logic [lg_width_lp-1:0] tag_o,
    output logic                   v_o
);

    logic [lg_width_lp-1:0] ptr_q, ptr_d;
    logic [lg_width_lp-1:0] idx;
    logic                   found;

    // Scan from the pointer, wrapping, and take the first requester.
    always_comb begin
        grants_o = '0;
        tag_o    = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < width_p; i++) begin
            idx = lg_width_lp'((32'(ptr_q) + i) % width_p);
            if (!found && reqs_i[idx]) begin
                found         = 1'b1;
                tag_o         = idx;
                grants_o[idx] = 1'b1;
            end
        end
        v_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i && found) begin
            ptr_d = (32'(tag_o) == width_p - 1) ? '0 : tag_o + lg_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bsg_cache_nb_to_test_dram_wr_split.sv
// Splits cache DMA block requests into DRAM-width test-DRAM commands.
// Round-robin picks one cache in IDLE (yumi same cycle), then SEND walks
// num_req_lp block-aligned commands. Each fired write pushes {tag, sub-mask}
// to tx; each fired read pushes its tag to rx, keeping side paths 1:1 with
// the DRAM command stream.
// Ports: core_clk_i, core_reset_i (async, active-high), bus (master modport:
//        dma_pkt_*, dram_req_*, tx_*, rx_tag_*).
// Option: BSG_CACHE_NB_TEST_DRAM_SKIP_EMPTY_EN skips write commands whose
//         sub-mask is all zero (one cycle per skipped slot, no push).
module bsg_cache_nb_to_test_dram_wr_split
    import bsg_cache_nb_test_dram_pkg::*;
#(
    parameter  int unsigned num_cache_p           = NUM_CACHE,
    parameter  int unsigned addr_width_p          = ADDR_WIDTH,
    parameter  int unsigned data_width_p          = DATA_WIDTH,
    parameter  int unsigned block_size_in_words_p = BLOCK_WORDS,
    parameter  int unsigned dram_data_width_p     = DRAM_DATA_WIDTH,
    localparam int unsigned num_req_lp            = block_size_in_words_p * data_width_p / dram_data_width_p,
    localparam int unsigned sub_mask_width_lp     = block_size_in_words_p / num_req_lp,
    localparam int unsigned lg_num_cache_lp       = safe_clog2(num_cache_p)
) (
    input  logic core_clk_i,
    input  logic core_reset_i,
    bsg_cache_nb_to_test_dram_wr_split_if.master bus
);

    localparam int unsigned block_bytes_lp    = block_size_in_words_p * data_width_p / 8;
    localparam int unsigned lg_block_bytes_lp = $clog2(block_bytes_lp);
    localparam int unsigned dram_bytes_lp     = dram_data_width_p / 8;
    localparam int unsigned lg_num_req_lp     = safe_clog2(num_req_lp);

    localparam logic [addr_width_p-1:0] block_align_mask_lp =
        {{(addr_width_p - lg_block_bytes_lp){1'b1}}, {lg_block_bytes_lp{1'b0}}};

    state_e                     state_q, state_d;
    logic [lg_num_req_lp-1:0]   k_q, k_d;
    logic [lg_num_cache_lp-1:0] tag_q, tag_d;
    dma_pkt_s                   pkt_q, pkt_d;

    logic [num_cache_p-1:0]       grants;
    logic [lg_num_cache_lp-1:0]   arb_tag;
    logic                         arb_v;
    logic                         arb_yumi_c;
    logic [sub_mask_width_lp-1:0] sub_mask_c;
    logic                         skip_c;
    logic                         last_c;
    logic                         side_ready_c;
    logic                         req_v_c;
    logic                         fire_c;
    tx_entry_s                    tx_c;

    // Yumi only while idle; held off during reset so nothing is consumed.
    assign arb_yumi_c = (state_q == ST_IDLE) & arb_v & ~core_reset_i;

    bsg_arb_round_robin #(.width_p(num_cache_p)) rr (
        .clk_i   (core_clk_i),
        .reset_i (core_reset_i),
        .reqs_i  (bus.dma_pkt_v_i),
        .yumi_i  (arb_yumi_c),
        .grants_o(grants),
        .tag_o   (arb_tag),
        .v_o     (arb_v)
    );

    assign sub_mask_c   = pkt_q.mask[k_q*sub_mask_width_lp +: sub_mask_width_lp];
    assign last_c       = (k_q == lg_num_req_lp'(num_req_lp - 1));
    assign side_ready_c = pkt_q.write_not_read ? bus.tx_ready_i : bus.rx_tag_ready_i;

`ifdef BSG_CACHE_NB_TEST_DRAM_SKIP_EMPTY_EN
    assign skip_c = pkt_q.write_not_read & ~(|sub_mask_c);
`else
    assign skip_c = 1'b0;
`endif

    // Next-state, packet latch and command gating.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tag_d   = tag_q;
        pkt_d   = pkt_q;
        req_v_c = 1'b0;
        fire_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_yumi_c) begin
                    tag_d                = arb_tag;
                    pkt_d.addr           = bus.dma_pkt_addr_i[arb_tag*addr_width_p +: addr_width_p]
                                           & block_align_mask_lp;
                    pkt_d.write_not_read = bus.dma_pkt_write_not_read_i[arb_tag];
                    pkt_d.mask           = bus.dma_pkt_mask_i[arb_tag*block_size_in_words_p +: block_size_in_words_p];
                    k_d                  = '0;
                    state_d              = ST_SEND;
                end
            end
            ST_SEND: begin
                req_v_c = ~skip_c & side_ready_c;
                fire_c  = req_v_c & bus.dram_req_ready_i;
                if (fire_c || skip_c) begin
                    if (last_c) begin
                        k_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + lg_num_req_lp'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            tag_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tag_q   <= tag_d;
            pkt_q   <= pkt_d;
        end
    end

    assign tx_c.tag  = tag_q;
    assign tx_c.mask = sub_mask_c;

    assign bus.dma_pkt_yumi_o            = arb_yumi_c ? grants : '0;
    assign bus.dram_req_v_o              = req_v_c;
    assign bus.dram_req_write_not_read_o = pkt_q.write_not_read;
    assign bus.dram_req_addr_o           = pkt_q.addr
                                           + addr_width_p'(k_q) * addr_width_p'(dram_bytes_lp);
    assign bus.tx_v_o                    = fire_c & pkt_q.write_not_read;
    assign bus.tx_tag_o                  = tx_c.tag;
    assign bus.tx_mask_o                 = tx_c.mask;
    assign bus.rx_tag_v_o                = fire_c & ~pkt_q.write_not_read;
    assign bus.rx_tag_o                  = tag_q;

endmodule

// File: tb/tb_bsg_cache_nb_to_test_dram_wr_split.sv
// Self-checking bench for bsg_cache_nb_to_test_dram_wr_split. A model holds
// the expected command list of the packet in flight plus the round-robin
// pointer; every cycle the DUT outputs are compared against it. Directed
// scenarios add literal expectations, then a randomized run follows.
module tb_bsg_cache_nb_to_test_dram_wr_split;
    import bsg_cache_nb_test_dram_pkg::*;

    localparam int unsigned NC = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 16;
    localparam int unsigned NR = 2;
    localparam int unsigned SW = 8;
    localparam int unsigned DB = 32;
`ifdef BSG_CACHE_NB_TEST_DRAM_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bsg_cache_nb_to_test_dram_wr_split_if bus ();

    bsg_cache_nb_to_test_dram_wr_split dut (
        .core_clk_i  (clk),
        .core_reset_i(rst),
        .bus         (bus)
    );

    int tests = 0;
    int fails = 0;
    int tx_count = 0;

    // Cache-side packets waiting to be consumed.
    logic        pend_v    [NC];
    logic [31:0] pend_addr [NC];
    logic        pend_wnr  [NC];
    logic [15:0] pend_mask [NC];
    logic dram_rdy, tx_rdy, rx_rdy;

    // Expected command slots of the packet in flight.
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  sub;
        logic        issue;
    } slot_t;
    slot_t mq[$];
    int    m_ptr = 0;
    logic  m_tag = 1'b0;
    logic  m_wnr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            bus.dma_pkt_v_i[i]              = pend_v[i];
            bus.dma_pkt_addr_i[i*AW +: AW]  = pend_addr[i];
            bus.dma_pkt_write_not_read_i[i] = pend_wnr[i];
            bus.dma_pkt_mask_i[i*BW +: BW]  = pend_mask[i];
        end
        bus.dram_req_ready_i = dram_rdy;
        bus.tx_ready_i       = tx_rdy;
        bus.rx_tag_ready_i   = rx_rdy;
    endtask

    task automatic settle();
        drive();
        #3;
    endtask

    task automatic set_pkt(input int c, input logic [31:0] a, input logic w, input logic [15:0] m);
        pend_v[c]    = 1'b1;
        pend_addr[c] = a;
        pend_wnr[c]  = w;
        pend_mask[c] = m;
    endtask

    function automatic bit pend_any();
        bit r = 1'b0;
        for (int i = 0; i < NC; i++) r |= pend_v[i];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ptr = 0;
    endtask

    // Compare all outputs against the model, advance the model, step a clock.
    task automatic cycle_end();
        logic [NC-1:0] exp_yumi;
        logic          exp_v, exp_tx, exp_rx, side;
        int            g;
        exp_yumi = '0;
        exp_v    = 1'b0;
        g        = -1;
        if (mq.size() == 0) begin
            for (int i = 0; i < NC; i++) begin
                int idx = (m_ptr + i) % NC;
                if (g < 0 && pend_v[idx]) g = idx;
            end
            if (g >= 0) exp_yumi[g] = 1'b1;
        end else begin
            side  = m_wnr ? tx_rdy : rx_rdy;
            exp_v = mq[0].issue && side;
        end
        exp_tx = exp_v && dram_rdy && m_wnr;
        exp_rx = exp_v && dram_rdy && !m_wnr;
        chk("yumi", 64'(bus.dma_pkt_yumi_o), 64'(exp_yumi));
        chk("dram_v", 64'(bus.dram_req_v_o), 64'(exp_v));
        chk("tx_v", 64'(bus.tx_v_o), 64'(exp_tx));
        chk("rx_v", 64'(bus.rx_tag_v_o), 64'(exp_rx));
        if (exp_v) begin
            chk("dram_addr", 64'(bus.dram_req_addr_o), 64'(mq[0].addr));
            chk("dram_wnr", 64'(bus.dram_req_write_not_read_o), 64'(m_wnr));
        end
        if (exp_tx) begin
            chk("tx_tag", 64'(bus.tx_tag_o), 64'(m_tag));
            chk("tx_mask", 64'(bus.tx_mask_o), 64'(mq[0].sub));
        end
        if (exp_rx) chk("rx_tag", 64'(bus.rx_tag_o), 64'(m_tag));
        if (bus.tx_v_o === 1'b1) tx_count++;

        if (g >= 0) begin
            for (int j = 0; j < NR; j++) begin
                slot_t s;
                s.addr  = (pend_addr[g] & ~32'h3F) + 32'(j * DB);
                s.sub   = pend_mask[g][j*SW +: SW];
                s.issue = !(SKIP && pend_wnr[g] && s.sub == 8'h00);
                mq.push_back(s);
            end
            m_tag     = 1'(g);
            m_wnr     = pend_wnr[g];
            m_ptr     = (g + 1) % NC;
            pend_v[g] = 1'b0;
        end else if (mq.size() > 0 && (!mq[0].issue || (exp_v && dram_rdy))) begin
            void'(mq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || pend_any()) && n < 40) begin
            settle();
            cycle_end();
            n++;
        end
        chk("drain_bound", 64'(n < 40), 64'd1);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < NC; i++) begin
            pend_v[i] = 1'b0; pend_addr[i] = '0; pend_wnr[i] = 1'b0; pend_mask[i] = '0;
        end
        dram_rdy = 1'b1; tx_rdy = 1'b1; rx_rdy = 1'b1;

        // Reset state, with a request already pending: nothing may be consumed.
        pend_v[0] = 1'b1;
        drive();
        #12;
        chk("rst_yumi", 64'(bus.dma_pkt_yumi_o), 64'd0);
        chk("rst_dram_v", 64'(bus.dram_req_v_o), 64'd0);
        chk("rst_tx_v", 64'(bus.tx_v_o), 64'd0);
        chk("rst_rx_v", 64'(bus.rx_tag_v_o), 64'd0);
        pend_v[0] = 1'b0;
        drive();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Cache 1 full write to 0x1234.
        set_pkt(1, 32'h1234, 1'b1, 16'hFFFF);
        settle();
        chk("t1_yumi", 64'(bus.dma_pkt_yumi_o), 64'h2);
        cycle_end();
        settle();
        chk("t1_addr0", 64'(bus.dram_req_addr_o), 64'h1200);
        chk("t1_tx0", 64'(bus.tx_v_o), 64'd1);
        chk("t1_tag0", 64'(bus.tx_tag_o), 64'd1);
        chk("t1_mask0", 64'(bus.tx_mask_o), 64'hFF);
        cycle_end();
        settle();
        chk("t1_addr1", 64'(bus.dram_req_addr_o), 64'h1220);
        chk("t1_tx1", 64'(bus.tx_v_o), 64'd1);
        cycle_end();
        settle();
        chk("t1_idle_v", 64'(bus.dram_req_v_o), 64'd0);
        cycle_end();

        // Both caches reading continuously: grants alternate 0,1,0.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NC; i++)
                if (!pend_v[i]) set_pkt(i, 32'h4000 + 32'(r * 'h100) + 32'(i * 'h40), 1'b0, 16'h0);
            settle();
            chk("rr_yumi", 64'(bus.dma_pkt_yumi_o), (r % 2 == 0) ? 64'h1 : 64'h2);
            cycle_end();
            for (int j = 0; j < 2; j++) begin
                settle();
                chk("rr_rx_v", 64'(bus.rx_tag_v_o), 64'd1);
                chk("rr_rx_tag", 64'(bus.rx_tag_o), 64'(r % 2));
                cycle_end();
            end
        end
        drain();

        // DRAM not ready for 5 cycles mid-packet.
        c0 = tx_count;
        set_pkt(0, 32'h8040, 1'b1, 16'hA5A5);
        settle(); cycle_end();
        settle(); cycle_end();
        dram_rdy = 1'b0;
        repeat (5) begin
            settle();
            chk("stall_v", 64'(bus.dram_req_v_o), 64'd1);
            chk("stall_addr", 64'(bus.dram_req_addr_o), 64'h8060);
            cycle_end();
        end
        dram_rdy = 1'b1;
        settle(); cycle_end();
        settle(); cycle_end();
        chk("stall_pushes", 64'(tx_count - c0), 64'd2);

        // tx side full: write held, read still proceeds.
        set_pkt(1, 32'h0100, 1'b1, 16'hFFFF);
        settle(); cycle_end();
        tx_rdy = 1'b0;
        repeat (3) begin
            settle();
            chk("txstall_v", 64'(bus.dram_req_v_o), 64'd0);
            cycle_end();
        end
        tx_rdy = 1'b1;
        drain();
        tx_rdy = 1'b0;
        set_pkt(0, 32'h0200, 1'b0, 16'h0);
        settle(); cycle_end();
        settle();
        chk("rd_not_blocked", 64'(bus.dram_req_v_o), 64'd1);
        cycle_end();
        drain();
        tx_rdy = 1'b1;

        // Half mask write.
        set_pkt(0, 32'h3000, 1'b1, 16'h00FF);
        settle(); cycle_end();
        settle();
        chk("half_addr0", 64'(bus.dram_req_addr_o), 64'h3000);
        chk("half_mask0", 64'(bus.tx_mask_o), 64'hFF);
        chk("half_tx0", 64'(bus.tx_v_o), 64'd1);
        cycle_end();
        settle();
`ifdef BSG_CACHE_NB_TEST_DRAM_SKIP_EMPTY_EN
        chk("half_skip_v", 64'(bus.dram_req_v_o), 64'd0);
        chk("half_skip_tx", 64'(bus.tx_v_o), 64'd0);
`else
        chk("half_addr1", 64'(bus.dram_req_addr_o), 64'h3020);
        chk("half_mask1", 64'(bus.tx_mask_o), 64'h00);
        chk("half_tx1", 64'(bus.tx_v_o), 64'd1);
`endif
        cycle_end();
        drain();

        // Reset in the middle of a packet; pointer must return to cache 0.
        set_pkt(0, 32'h5000, 1'b0, 16'h0);
        settle(); cycle_end();
        settle();
        chk("pre_rst_v", 64'(bus.dram_req_v_o), 64'd1);
        cycle_end();
        set_pkt(1, 32'h6000, 1'b0, 16'h0);
        drive();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_v", 64'(bus.dram_req_v_o), 64'd0);
        chk("async_rst_rx", 64'(bus.rx_tag_v_o), 64'd0);
        chk("async_rst_yumi", 64'(bus.dma_pkt_yumi_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_pkt(0, 32'h7000, 1'b0, 16'h0);
        settle();
        chk("post_rst_grant", 64'(bus.dma_pkt_yumi_o), 64'h1);
        cycle_end();
        drain();

        // Randomized traffic and back-pressure.
        repeat (3000) begin
            for (int i = 0; i < NC; i++) begin
                if (!pend_v[i] && ($urandom % 3 == 0)) begin
                    logic [15:0] m;
                    m[7:0]  = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
                    m[15:8] = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
                    set_pkt(i, $urandom, 1'($urandom), m);
                end
            end
            dram_rdy = ($urandom % 4) != 0;
            tx_rdy   = ($urandom % 5) != 0;
            rx_rdy   = ($urandom % 5) != 0;
            settle();
            cycle_end();
        end
        dram_rdy = 1'b1; tx_rdy = 1'b1; rx_rdy = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_cache_nb_to_test_dram_wr_split.md
# bsg_cache_nb_to_test_dram_wr_split

Request-side splitter between the non-blocking caches' DMA packet ports and the test DRAM command port. It round-robin arbitrates DMA packets from `num_cache_p` caches and breaks each block request into `num_req_lp` DRAM-width commands with block-aligned addresses. For writes it pushes one {tag, sub-mask} entry per command into the tx data path. For reads it pushes one tag per command into the rx tag path.

## Interface
Parameters:
- `num_cache_p`, none: number of caches.
- `addr_width_p`, none: DMA byte-address width.
- `data_width_p`, none: cache word width in bits.
- `block_size_in_words_p`, none: words per block.
- `dram_data_width_p`, none: bits per DRAM command.
- `num_req_lp`, `block_size_in_words_p*data_width_p/dram_data_width_p`: commands per block.
- `sub_mask_width_lp`, `block_size_in_words_p/num_req_lp`: mask bits per command.
- `lg_num_cache_lp`, `BSG_SAFE_CLOG2(num_cache_p)`: tag width.

Ports:
- `core_clk_i`, in, 1: the single clock.
- `core_reset_i`, in, 1: reset, asynchronous, active-high.
- `dma_pkt_v_i`, in, `num_cache_p`: packet valid per cache.
- `dma_pkt_addr_i`, in, `num_cache_p*addr_width_p`: byte address per cache.
- `dma_pkt_write_not_read_i`, in, `num_cache_p`: 1 means write.
- `dma_pkt_mask_i`, in, `num_cache_p*block_size_in_words_p`: word mask for writes.
- `dma_pkt_yumi_o`, out, `num_cache_p`: packet consumed, at most one bit high.
- `dram_req_v_o`, out, 1: DRAM command valid.
- `dram_req_write_not_read_o`, out, 1: command type.
- `dram_req_addr_o`, out, `addr_width_p`: command byte address.
- `dram_req_ready_i`, in, 1: DRAM accepts the command.
- `tx_v_o`, out, 1: push to the tx tag fifo.
- `tx_tag_o`, out, `lg_num_cache_lp`: cache index.
- `tx_mask_o`, out, `sub_mask_width_lp`: word mask for this command.
- `tx_ready_i`, in, 1: tx tag fifo has space.
- `rx_tag_v_o`, out, 1: push to the rx tag fifo.
- `rx_tag_o`, out, `lg_num_cache_lp`: cache index.
- `rx_tag_ready_i`, in, 1: rx tag fifo has space.

## Operation
FSM states are IDLE and SEND.
- **IDLE:**
  - If any `dma_pkt_v_i` bit is high, the round-robin arbiter grants one cache and `dma_pkt_yumi_o[grant]` is driven the same cycle.
  - The packet is latched: tag = grant index, base = addr with low `log2(block bytes)` bits cleared, type, mask.
  - Counter k is cleared and the state moves to SEND.
- **SEND:**
  - Command k is presented with `dram_req_addr_o` = base + k*(`dram_data_width_p`/8) and sub-mask = mask bits [k*`sub_mask_width_lp` +: `sub_mask_width_lp`].
  - `dram_req_v_o` is gated by the side-path ready: `tx_ready_i` for writes, `rx_tag_ready_i` for reads.
  - fire = `dram_req_v_o` & `dram_req_ready_i`.
  - On fire, `tx_v_o` (write) or `rx_tag_v_o` (read) is pulsed in the same cycle, so DRAM commands and tag entries stay 1:1 and in order.
  - On fire with k = `num_req_lp`-1, the state returns to IDLE. Otherwise k increments.
- Arbitration: the round-robin pointer advances past the granted cache only on grant. After reset the pointer is 0, so cache 0 has highest priority.
- The address is truncated to `addr_width_p`. Block-offset bits of the input address are ignored.

## Timing
- Reset values: all `*_v_o` and `dma_pkt_yumi_o` = 0, state IDLE, k = 0, RR pointer = 0, latched registers = 0.
- Yumi is combinational from `dma_pkt_v_i` in IDLE. The first command appears the cycle after the yumi.
- Peak throughput is `num_req_lp`+1 cycles per packet (one IDLE bubble).
- Stalls:
  - `dram_req_ready_i` low, or side-ready low, holds every SEND output stable. No tag is pushed without a fired command.
  - Side-ready dropping while `dram_req_ready_i` is high means no fire.
- Reset is asynchronous: asserting reset mid-SEND aborts the packet immediately, and the remaining commands are never issued.
- Packets arriving while in SEND wait and are not yumi'd.

## Configuration
- `BSG_CACHE_NB_TEST_DRAM_SKIP_EMPTY_EN` defined: in SEND, a write command whose sub-mask is all zero is not issued. k advances without fire, one cycle per skipped slot, and no tx entry is pushed.
  - A write packet with an all-zero mask takes one SEND pass with no outputs and then returns to IDLE.
- Undefined: every write issues all `num_req_lp` commands, including ones with a zero sub-mask.
- Reads are unaffected either way.

## Structure
- Shared package `bsg_cache_nb_test_dram_pkg` holds:
  - the per-cache DMA packet struct (addr, write_not_read, mask);
  - the state enum;
  - the tx entry struct {tag, mask}.
- Natural sub-module: `bsg_arb_round_robin` for the grant, with yumi driven only in IDLE.
- The counter, FSM and address generation are local.

## Test plan
- num_cache_p=2, num_req_lp=2, dram width 256, block 64B, all readies high; cache1 write to addr 0x1234, mask all 1 -> yumi[1] at t0; commands 0x1200 and 0x1220 at t1 and t2, each with a tx push of tag=1 and full sub-mask.
- Both caches valid reads, back to back -> grants alternate 0,1,0. Each grant gives two read commands and two rx tags in order.
- Write with `dram_req_ready_i` low for 5 cycles mid-packet -> outputs stable, no extra tx push, exactly 2 pushes total.
- Write with `tx_ready_i` low for 3 cycles -> `dram_req_v_o` low during the stall, no fire. Read packets are not blocked by low `tx_ready_i`.
- Write mask 0x00FF (first half only), with the macro defined -> one command at base, one tx push. With the macro undefined -> two commands, the second with sub-mask 0.
- Reset asserted in SEND after the first command -> all valids 0 asynchronously. After release, state is IDLE and the next grant goes to cache 0.
